// File: rtl/noc_endpoint.sv
// NoC endpoint: TX packet FIFO serialised MSB-first into flits, RX flits reassembled into packets.
// Optional statistics counters are enabled by defining NOC_EP_STATS_EN.
module noc_endpoint #(
    parameter int NODEID = 0,
    parameter int PKT_W  = 32,
    parameter int FLIT_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [FLIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [FLIT_W-1:0] payload_inbound
`ifdef NOC_EP_STATS_EN
    ,
    output logic [15:0]       tx_pkts,
    output logic [15:0]       rx_pkts,
    output logic [15:0]       rx_aborts
`endif
);

    localparam int BEATS = PKT_W / FLIT_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W = $clog2(BEATS + 1);

    if ((PKT_W % FLIT_W) != 0) begin : gBadFlitWidth
        $error("noc_endpoint: PKT_W must be a multiple of FLIT_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
        $error("noc_endpoint: DEPTH must be a power of two and at least 2");
    end
    if (NODEID < 0) begin : gBadNodeId
        $error("noc_endpoint: NODEID must be non-negative");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DONE} rxState_t;

    logic [PKT_W-1:0] fifoMem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             fifoEmpty, fifoFull, doPush, doPop, txPopReq;

    txState_t         txState_q, txState_d;
    logic [PKT_W-1:0] txShift_q, txShift_d;
    logic [IDX_W-1:0] beatIdx_q, beatIdx_d;
    logic             txLastBeat;

    rxState_t         rxState_q, rxState_d;
    logic [PKT_W-1:0] rxHold_q, rxHold_d;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic [PKT_W-1:0] pktOut_q, pktOut_d;
    logic             rxAbort;

    assign fifoFull  = (count_q == (PTR_W + 1)'(DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign doPush    = pkt_in_avail && !fifoFull;
    assign doPop     = txPopReq && !fifoEmpty;
    assign cQ_full   = fifoFull;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) fifoMem_q[wrPtr_q] <= pkt_in;
    end

    assign txLastBeat = (txState_q == TX_SEND) && (beatIdx_q == IDX_W'(BEATS - 1));

    always_comb begin
        txState_d = txState_q;
        txShift_d = txShift_q;
        beatIdx_d = beatIdx_q;
        txPopReq  = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (!fifoEmpty) begin
                    txPopReq  = 1'b1;
                    txShift_d = fifoMem_q[rdPtr_q];
                    txState_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (free_outbound) begin
                    beatIdx_d = '0;
                    txState_d = TX_SEND;
                end
            end
            TX_SEND: begin
                txShift_d = txShift_q << FLIT_W;
                beatIdx_d = beatIdx_q + IDX_W'(1);
                if (txLastBeat) begin
                    beatIdx_d = '0;
                    if (!fifoEmpty) begin
                        txPopReq  = 1'b1;
                        txShift_d = fifoMem_q[rdPtr_q];
                        txState_d = TX_LOAD;
                    end else begin
                        txState_d = TX_IDLE;
                    end
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            txState_q <= TX_IDLE;
            txShift_q <= '0;
            beatIdx_q <= '0;
        end else begin
            txState_q <= txState_d;
            txShift_q <= txShift_d;
            beatIdx_q <= beatIdx_d;
        end
    end

    assign put_outbound     = (txState_q == TX_SEND);
    assign payload_outbound = put_outbound ? txShift_q[PKT_W-1 -: FLIT_W] : '0;

    // A full hold register waits one cycle in RECV before DONE, so input is ignored there too.
    always_comb begin
        rxState_d = rxState_q;
        rxHold_d  = rxHold_q;
        rxCnt_d   = rxCnt_q;
        pktOut_d  = pktOut_q;
        rxAbort   = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (put_inbound) begin
                    rxHold_d  = PKT_W'(payload_inbound);
                    rxCnt_d   = CNT_W'(1);
                    rxState_d = (BEATS == 1) ? RX_DONE : RX_RECV;
                end
            end
            RX_RECV: begin
                if (rxCnt_q == CNT_W'(BEATS)) begin
                    rxState_d = RX_DONE;
                end else if (put_inbound) begin
                    rxHold_d = (rxHold_q << FLIT_W) | PKT_W'(payload_inbound);
                    rxCnt_d  = rxCnt_q + CNT_W'(1);
                end else begin
                    rxAbort   = 1'b1;
                    rxCnt_d   = '0;
                    rxState_d = RX_IDLE;
                end
            end
            RX_DONE: rxState_d = RX_IDLE;
            default: rxState_d = RX_IDLE;
        endcase
        if ((rxState_d == RX_DONE) && (rxState_q != RX_DONE)) pktOut_d = rxHold_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rxState_q <= RX_IDLE;
            rxHold_q  <= '0;
            rxCnt_q   <= '0;
            pktOut_q  <= '0;
        end else begin
            rxState_q <= rxState_d;
            rxHold_q  <= rxHold_d;
            rxCnt_q   <= rxCnt_d;
            pktOut_q  <= pktOut_d;
        end
    end

    assign free_inbound  = (rxState_q == RX_IDLE);
    assign pkt_out_avail = (rxState_q == RX_DONE);
    assign pkt_out       = pktOut_q;

`ifdef NOC_EP_STATS_EN
    logic [15:0] txPkts_q, rxPkts_q, rxAborts_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            txPkts_q   <= '0;
            rxPkts_q   <= '0;
            rxAborts_q <= '0;
        end else begin
            if (txLastBeat && (txPkts_q != 16'hFFFF))        txPkts_q   <= txPkts_q + 16'd1;
            if (pkt_out_avail && (rxPkts_q != 16'hFFFF))     rxPkts_q   <= rxPkts_q + 16'd1;
            if (rxAbort && (rxAborts_q != 16'hFFFF))         rxAborts_q <= rxAborts_q + 16'd1;
        end
    end

    assign tx_pkts   = txPkts_q;
    assign rx_pkts   = rxPkts_q;
    assign rx_aborts = rxAborts_q;
`endif

endmodule

// File: tb/tb_noc_endpoint.sv
// Bench for noc_endpoint: directed scenarios plus a randomized phase checked against a
// queue-based model of packets and flits. Two instances: default 32/8/4 and 64/16/8.
module tb_noc_endpoint;

    localparam int PKT_W  = 32;
    localparam int FLIT_W = 8;
    localparam int BEATS  = PKT_W / FLIT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_b;
    logic [31:0]       pktIn;
    logic              pktInAvail;
    logic              cqFull;
    logic [31:0]       pktOut;
    logic              pktOutAvail;
    logic              freeOutbound;
    logic              putOutbound;
    logic [7:0]        payloadOutbound;
    logic              freeInbound;
    logic              putInbound;
    logic [7:0]        payloadInbound;

    logic [63:0]       pktInB;
    logic              pktInAvailB;
    logic              cqFullB;
    logic [63:0]       pktOutB;
    logic              pktOutAvailB;
    logic              freeOutboundB;
    logic              putOutboundB;
    logic [15:0]       payloadOutboundB;
    logic              freeInboundB;
    logic              putInboundB;
    logic [15:0]       payloadInboundB;

`ifdef NOC_EP_STATS_EN
    logic [15:0] txPktsA, rxPktsA, rxAbortsA;
    logic [15:0] txPktsB, rxPktsB, rxAbortsB;
`endif

    noc_endpoint #(.NODEID(1), .PKT_W(32), .FLIT_W(8), .DEPTH(4)) dutA (
        .clk(clk), .rst_b(rst_b),
        .pkt_in(pktIn), .pkt_in_avail(pktInAvail), .cQ_full(cqFull),
        .pkt_out(pktOut), .pkt_out_avail(pktOutAvail),
        .free_outbound(freeOutbound), .put_outbound(putOutbound), .payload_outbound(payloadOutbound),
        .free_inbound(freeInbound), .put_inbound(putInbound), .payload_inbound(payloadInbound)
`ifdef NOC_EP_STATS_EN
        , .tx_pkts(txPktsA), .rx_pkts(rxPktsA), .rx_aborts(rxAbortsA)
`endif
    );

    noc_endpoint #(.NODEID(2), .PKT_W(64), .FLIT_W(16), .DEPTH(8)) dutB (
        .clk(clk), .rst_b(rst_b),
        .pkt_in(pktInB), .pkt_in_avail(pktInAvailB), .cQ_full(cqFullB),
        .pkt_out(pktOutB), .pkt_out_avail(pktOutAvailB),
        .free_outbound(freeOutboundB), .put_outbound(putOutboundB), .payload_outbound(payloadOutboundB),
        .free_inbound(freeInboundB), .put_inbound(putInboundB), .payload_inbound(payloadInboundB)
`ifdef NOC_EP_STATS_EN
        , .tx_pkts(txPktsB), .rx_pkts(rxPktsB), .rx_aborts(rxAbortsB)
`endif
    );

    int assertCount = 0;
    int failCount   = 0;
    int sampleIdx   = 0;

    // TX model: flits still owed by the endpoint, in order, and position inside the current packet.
    logic [63:0] expBeats [$];
    int          txPhase     = 0;
    int          txDoneModel = 0;
    logic        pushReq     = 1'b0;
    logic [31:0] pushData    = '0;

    // RX model: flits still to drive, expected pulse sample, busy window and held output.
    logic [7:0]  rxBeatsQ [$];
    int          rxJunk       = 0;
    int          availAt      = -1;
    logic [31:0] availVal     = '0;
    int          busyEnd      = -1;
    logic [31:0] expPktOut    = '0;
    int          rxDoneModel  = 0;
    int          rxAbortModel = 0;

    function automatic logic [63:0] beatOf(input logic [63:0] pkt, input int pktW, input int flitW, input int j);
        logic [63:0] mask;
        mask = (64'd1 << flitW) - 64'd1;
        return (pkt >> (pktW - flitW * (j + 1))) & mask;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushPacket(input logic [31:0] data, input bit accepted);
        pushReq  = 1'b1;
        pushData = data;
        if (accepted)
            for (int j = 0; j < BEATS; j++) expBeats.push_back(beatOf(64'(data), PKT_W, FLIT_W, j));
    endtask

    task automatic startRx(input logic [31:0] data, input int k);
        int a;
        a = sampleIdx + 1;
        for (int j = 0; j < k; j++) rxBeatsQ.push_back(8'(beatOf(64'(data), PKT_W, FLIT_W, j)));
        if (k == BEATS) begin
            availAt  = a + BEATS;
            availVal = data;
            busyEnd  = a + BEATS;
            rxJunk   = 2;
        end else begin
            busyEnd = a + k - 1;
            rxAbortModel++;
        end
    endtask

    function automatic bit rxIdle();
        return (sampleIdx > busyEnd) && (rxBeatsQ.size() == 0) && (rxJunk == 0);
    endfunction

    task automatic applyStimulus();
        pktInAvail = pushReq;
        pktIn      = pushData;
        pushReq    = 1'b0;
        if (rxBeatsQ.size() != 0) begin
            putInbound     = 1'b1;
            payloadInbound = rxBeatsQ.pop_front();
        end else if (rxJunk > 0) begin
            putInbound     = 1'($urandom_range(0, 1));
            payloadInbound = 8'($urandom);
            rxJunk--;
        end else begin
            putInbound     = 1'b0;
            payloadInbound = '0;
        end
    endtask

    task automatic resetModel();
        expBeats.delete();
        rxBeatsQ.delete();
        txPhase      = 0;
        txDoneModel  = 0;
        rxJunk       = 0;
        availAt      = -1;
        busyEnd      = -1;
        expPktOut    = '0;
        rxDoneModel  = 0;
        rxAbortModel = 0;
    endtask

    task automatic observeOutputs();
        logic expAvail;
        if (putOutbound) begin
            checkOutput("txBeatExpected", 64'(expBeats.size() != 0), 64'd1);
            if (expBeats.size() != 0) checkOutput("txPayload", 64'(payloadOutbound), expBeats.pop_front());
            txPhase++;
            if (txPhase == BEATS) begin
                txPhase = 0;
                txDoneModel++;
            end
        end else begin
            checkOutput("txIdlePayload", 64'(payloadOutbound), 64'd0);
            checkOutput("txBurstGap", 64'(txPhase == 0), 64'd1);
        end
        expAvail = (sampleIdx == availAt);
        if (expAvail) begin
            expPktOut = availVal;
            rxDoneModel++;
        end
        checkOutput("rxAvail", 64'(pktOutAvail), 64'(expAvail));
        checkOutput("rxPktOut", 64'(pktOut), 64'(expPktOut));
        checkOutput("rxFreeInbound", 64'(freeInbound), 64'(sampleIdx > busyEnd));
    endtask

    task automatic tick();
        applyStimulus();
        @(posedge clk);
        @(negedge clk);
        sampleIdx++;
        if (!rst_b) resetModel();
        else        observeOutputs();
    endtask

    task automatic doReset(input int cycles);
        rst_b = 1'b0;
        repeat (cycles) tick();
        checkOutput("rstPutOutbound", 64'(putOutbound), 64'd0);
        checkOutput("rstPayload", 64'(payloadOutbound), 64'd0);
        checkOutput("rstPktOut", 64'(pktOut), 64'd0);
        checkOutput("rstPktOutAvail", 64'(pktOutAvail), 64'd0);
        checkOutput("rstCqFull", 64'(cqFull), 64'd0);
        checkOutput("rstFreeInbound", 64'(freeInbound), 64'd1);
        checkOutput("rstPutOutboundB", 64'(putOutboundB), 64'd0);
        checkOutput("rstCqFullB", 64'(cqFullB), 64'd0);
        checkOutput("rstFreeInboundB", 64'(freeInboundB), 64'd1);
        checkOutput("rstPktOutB", pktOutB, 64'd0);
        rst_b = 1'b1;
    endtask

    logic [7:0]  t1Beats [4];
    logic [15:0] t5Beats [4];
    logic [31:0] t2Pkts  [6];

    initial begin
        int lowCount;
        int availCount;
        int k;

        t1Beats = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        t5Beats = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        t2Pkts  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

        rst_b = 1'b0;
        pktIn = '0; pktInAvail = 1'b0; freeOutbound = 1'b0; putInbound = 1'b0; payloadInbound = '0;
        pktInB = '0; pktInAvailB = 1'b0; freeOutboundB = 1'b0; putInboundB = 1'b0; payloadInboundB = '0;

        $display("[TB] reset");
        doReset(3);

        $display("[TB] single packet, beat order and latency");
        freeOutbound = 1'b1;
        pushPacket(32'hDEADBEEF, 1'b1);
        tick();
        checkOutput("t1PushCycle", 64'(putOutbound), 64'd0);
        tick();
        checkOutput("t1LoadCycle", 64'(putOutbound), 64'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("t1BeatValid", 64'(putOutbound), 64'd1);
            checkOutput("t1BeatValue", 64'(payloadOutbound), 64'(t1Beats[j]));
        end
        tick();
        checkOutput("t1AfterLast", 64'(putOutbound), 64'd0);

        $display("[TB] fill FIFO with router stalled");
        freeOutbound = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pushPacket(t2Pkts[i], 1'b1);
            tick();
            if (i == 3) checkOutput("t2NotFullAfter4", 64'(cqFull), 64'd0);
        end
        checkOutput("t2FullAfter5", 64'(cqFull), 64'd1);
        pushPacket(t2Pkts[5], 1'b0);
        tick();
        checkOutput("t2StillFull", 64'(cqFull), 64'd1);
        freeOutbound = 1'b1;
        repeat (40) tick();
        checkOutput("t2Drained", 64'(expBeats.size()), 64'd0);
        checkOutput("t2NotFullAfterDrain", 64'(cqFull), 64'd0);

        $display("[TB] receive one packet");
        startRx(32'h12345678, BEATS);
        lowCount = 0;
        availCount = 0;
        repeat (8) begin
            tick();
            if (!freeInbound) lowCount++;
            if (pktOutAvail) availCount++;
        end
        checkOutput("t3FreeLowCycles", 64'(lowCount), 64'd5);
        checkOutput("t3AvailPulses", 64'(availCount), 64'd1);
        checkOutput("t3PktOut", 64'(pktOut), 64'h12345678);

        $display("[TB] aborted receive");
        startRx(32'hCAFEF00D, 2);
        availCount = 0;
        repeat (6) begin
            tick();
            if (pktOutAvail) availCount++;
        end
        checkOutput("t4NoAvail", 64'(availCount), 64'd0);
        checkOutput("t4PktOutHeld", 64'(pktOut), 64'h12345678);
`ifdef NOC_EP_STATS_EN
        checkOutput("t4RxAborts", 64'(rxAbortsA), 64'd1);
`endif

        $display("[TB] 64/16/8 instance");
        freeOutboundB = 1'b1;
        pktInB = 64'h0123_4567_89AB_CDEF;
        pktInAvailB = 1'b1;
        tick();
        pktInAvailB = 1'b0;
        checkOutput("t5PushCycle", 64'(putOutboundB), 64'd0);
        tick();
        checkOutput("t5LoadCycle", 64'(putOutboundB), 64'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("t5BeatValid", 64'(putOutboundB), 64'd1);
            checkOutput("t5BeatValue", 64'(payloadOutboundB), 64'(t5Beats[j]));
        end
        tick();
        checkOutput("t5AfterLast", 64'(putOutboundB), 64'd0);
        checkOutput("t5IdlePayload", 64'(payloadOutboundB), 64'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            freeOutbound = 1'($urandom_range(0, 1));
            if (!cqFull && ($urandom_range(0, 2) == 0)) pushPacket($urandom, 1'b1);
            if (rxIdle() && ($urandom_range(0, 1) == 0)) begin
                k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BEATS - 1)) : BEATS;
                startRx($urandom, k);
            end
            tick();
        end
        freeOutbound = 1'b1;
        repeat (60) tick();
        checkOutput("randDrained", 64'(expBeats.size()), 64'd0);
`ifdef NOC_EP_STATS_EN
        checkOutput("statTxPkts", 64'(txPktsA), 64'(txDoneModel));
        checkOutput("statRxPkts", 64'(rxPktsA), 64'(rxDoneModel));
        checkOutput("statRxAborts", 64'(rxAbortsA), 64'(rxAbortModel));
`endif

        $display("[TB] reset in the middle of traffic");
        freeOutbound = 1'b1;
        pushPacket(32'hA1A2A3A4, 1'b1);
        tick();
        pushPacket(32'hB1B2B3B4, 1'b1);
        tick();
        pushPacket(32'hC1C2C3C4, 1'b1);
        startRx(32'h9ABCDEF0, BEATS);
        tick();
        for (int i = 0; i < 30 && txPhase != 3; i++) tick();
        checkOutput("t6ReachedBeat2", 64'(txPhase), 64'd3);
        rst_b = 1'b0;
        tick();
        checkOutput("t6PutOutbound", 64'(putOutbound), 64'd0);
        checkOutput("t6CqFull", 64'(cqFull), 64'd0);
        checkOutput("t6FreeInbound", 64'(freeInbound), 64'd1);
        checkOutput("t6PktOutAvail", 64'(pktOutAvail), 64'd0);
        rst_b = 1'b1;
        repeat (10) begin
            tick();
            checkOutput("t6FifoEmptyNoFull", 64'(cqFull), 64'd0);
        end
        pushPacket(32'h0F0E0D0C, 1'b1);
        repeat (10) tick();
        checkOutput("t6PostResetDrained", 64'(expBeats.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
